// File: rtl/hc05_at_pkg.sv
// ============================================================================
// Module      : hc05_at_pkg
// Description : Shared types and constants for the HC-05 AT responder:
//               parser/rx state encodings, AT byte constants, response ROM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hc05_at_pkg;

  typedef enum logic [2:0] {
    P_IDLE    = 3'd0,
    P_T       = 3'd1,
    P_BODY    = 3'd2,
    P_LF      = 3'd3,
    P_DISCARD = 3'd4
  } parser_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    RSP_OK   = 2'd0,
    RSP_ERR  = 2'd1,
    RSP_ECHO = 2'd2
  } rsp_kind_e;

  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_T  = 8'h54;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  localparam logic [2:0] RSP_OK_LEN  = 3'd4;
  localparam logic [2:0] RSP_ERR_LEN = 3'd7;

  // Response ROM: "OK\r\n" and "ERROR\r\n"
  function automatic logic [7:0] rsp_rom(input logic is_err, input logic [2:0] idx);
    logic [7:0] b;
    b = CH_LF;
    if (is_err) begin
      case (idx)
        3'd0:    b = 8'h45;
        3'd1:    b = 8'h52;
        3'd2:    b = 8'h52;
        3'd3:    b = 8'h4F;
        3'd4:    b = 8'h52;
        3'd5:    b = CH_CR;
        default: b = CH_LF;
      endcase
    end else begin
      case (idx)
        3'd0:    b = 8'h4F;
        3'd1:    b = 8'h4B;
        3'd2:    b = CH_CR;
        default: b = CH_LF;
      endcase
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hc05_uart_rx.sv
// ============================================================================
// Module      : hc05_uart_rx
// Description : 8N1 bit sampler. Start detected on a falling edge, confirmed
//               at half a bit, data sampled every bit period LSB first, stop
//               sampled at 9.5 bit periods.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hc05_uart_rx
  import hc05_at_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] cpd,
  input  logic       rx_line,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       framing_err
);

  rx_state_e  st_q, st_d;
  logic [9:0] tick_q, tick_d;
  logic [9:0] cpd_q, cpd_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       prev_q;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;

  // State register; prev_q resets high so an idle-high line is not a start edge
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q    <= RX_IDLE;
      tick_q  <= 10'd0;
      cpd_q   <= 10'd0;
      bit_q   <= 3'd0;
      sh_q    <= 8'h00;
      prev_q  <= 1'b1;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      tick_q  <= tick_d;
      cpd_q   <= cpd_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      prev_q  <= rx_line;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: countdown to each sample point, bit period latched at frame start
  always_comb begin
    st_d    = st_q;
    tick_d  = tick_q;
    cpd_d   = cpd_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (st_q)
      RX_IDLE: begin
        if (prev_q && !rx_line) begin
          st_d   = RX_START;
          cpd_d  = cpd;
          tick_d = (cpd >> 1) - 10'd1;
        end
      end
      RX_START: begin
        if (tick_q != 10'd0) begin
          tick_d = tick_q - 10'd1;
        end else if (rx_line) begin
          st_d = RX_IDLE;
        end else begin
          st_d   = RX_DATA;
          tick_d = cpd_q - 10'd1;
          bit_d  = 3'd0;
        end
      end
      RX_DATA: begin
        if (tick_q != 10'd0) begin
          tick_d = tick_q - 10'd1;
        end else begin
          sh_d   = {rx_line, sh_q[7:1]};
          tick_d = cpd_q - 10'd1;
          if (bit_q == 3'd7) st_d = RX_STOP;
          else               bit_d = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (tick_q != 10'd0) begin
          tick_d = tick_q - 10'd1;
        end else begin
          st_d = RX_IDLE;
          if (rx_line) valid_d = 1'b1;
          else         ferr_d  = 1'b1;
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  assign rx_byte     = sh_q;
  assign rx_valid    = valid_q;
  assign framing_err = ferr_q;

endmodule

`default_nettype wire

// File: rtl/hc05_at_responder.sv
// ============================================================================
// Module      : hc05_at_responder
// Description : HC-05 stand-in. Parses "AT...\r\n" commands from rx_line and
//               answers "OK\r\n" / "ERROR\r\n" on tx_line; data mode delivers
//               raw bytes on data_byte/data_valid.
// Options     : HC05_ECHO_EN - echo data-mode bytes on tx_line through a
//               1-deep holding register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hc05_at_responder #(
  parameter int CMD_MAX = 32,
  parameter int CPD_MIN = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] cycles_per_databit,
  input  logic       at_mode,
  input  logic       rx_line,
  output logic       tx_line,
  output logic [7:0] data_byte,
  output logic       data_valid,
  output logic       framing_err,
  output logic       overrun,
  output logic       busy,
  output logic [7:0] cmd_count,
  output logic [7:0] err_count
);
  import hc05_at_pkg::*;

  localparam int         LEN_W     = $clog2(CMD_MAX + 1);
  localparam logic [9:0] CPD_FLOOR = 10'(CPD_MIN);

  logic [9:0] cpd;
  logic [7:0] rx_byte;
  logic       rx_valid;

  assign cpd = (cycles_per_databit < CPD_FLOOR) ? CPD_FLOOR : cycles_per_databit;

  hc05_uart_rx u_rx (
    .clock       (clock),
    .reset       (reset),
    .cpd         (cpd),
    .rx_line     (rx_line),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .framing_err (framing_err)
  );

  parser_state_e    pst_q, pst_d;
  logic [LEN_W-1:0] body_len_q, body_len_d;
  logic             busy_q, busy_d;
  logic             tx_line_q, tx_line_d;
  logic [8:0]       tx_sr_q, tx_sr_d;      // remaining data bits + stop
  logic [3:0]       tx_bit_q, tx_bit_d;    // 0 = start, 9 = stop
  logic [9:0]       tx_tick_q, tx_tick_d;
  logic [9:0]       tx_cpd_q, tx_cpd_d;
  rsp_kind_e        rsp_kind_q, rsp_kind_d;
  logic [2:0]       rsp_idx_q, rsp_idx_d;
  logic [7:0]       cmd_count_q, cmd_count_d;
  logic [7:0]       err_count_q, err_count_d;
  logic [7:0]       data_byte_q, data_byte_d;
  logic             data_valid_q, data_valid_d;
  logic             overrun_q, overrun_d;
  logic             load_en;
  logic [7:0]       load_byte;
  logic [2:0]       rsp_last;
`ifdef HC05_ECHO_EN
  logic [7:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
`endif

  assign rsp_last = (rsp_kind_q == RSP_ERR) ? (RSP_ERR_LEN - 3'd1) : (RSP_OK_LEN - 3'd1);

  // State register; reset abandons any frame and idles tx_line
  always_ff @(posedge clock) begin
    if (reset) begin
      pst_q        <= P_IDLE;
      body_len_q   <= '0;
      busy_q       <= 1'b0;
      tx_line_q    <= 1'b1;
      tx_sr_q      <= 9'h1FF;
      tx_bit_q     <= 4'd0;
      tx_tick_q    <= 10'd0;
      tx_cpd_q     <= 10'd0;
      rsp_kind_q   <= RSP_OK;
      rsp_idx_q    <= 3'd0;
      cmd_count_q  <= 8'd0;
      err_count_q  <= 8'd0;
      data_byte_q  <= 8'h00;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef HC05_ECHO_EN
      hold_q       <= 8'h00;
      hold_vld_q   <= 1'b0;
`endif
    end else begin
      pst_q        <= pst_d;
      body_len_q   <= body_len_d;
      busy_q       <= busy_d;
      tx_line_q    <= tx_line_d;
      tx_sr_q      <= tx_sr_d;
      tx_bit_q     <= tx_bit_d;
      tx_tick_q    <= tx_tick_d;
      tx_cpd_q     <= tx_cpd_d;
      rsp_kind_q   <= rsp_kind_d;
      rsp_idx_q    <= rsp_idx_d;
      cmd_count_q  <= cmd_count_d;
      err_count_q  <= err_count_d;
      data_byte_q  <= data_byte_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
`ifdef HC05_ECHO_EN
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
`endif
    end
  end

  // Parser, response sequencer and tx shifter
  always_comb begin
    pst_d        = pst_q;
    body_len_d   = body_len_q;
    busy_d       = busy_q;
    tx_line_d    = tx_line_q;
    tx_sr_d      = tx_sr_q;
    tx_bit_d     = tx_bit_q;
    tx_tick_d    = tx_tick_q;
    tx_cpd_d     = tx_cpd_q;
    rsp_kind_d   = rsp_kind_q;
    rsp_idx_d    = rsp_idx_q;
    cmd_count_d  = cmd_count_q;
    err_count_d  = err_count_q;
    data_byte_d  = data_byte_q;
    data_valid_d = 1'b0;
    overrun_d    = 1'b0;
    load_en      = 1'b0;
    load_byte    = 8'h00;
`ifdef HC05_ECHO_EN
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
`endif

    // Received byte: data delivery, overrun, or one parser step
    if (rx_valid) begin
      if (!at_mode) begin
        data_byte_d  = rx_byte;
        data_valid_d = 1'b1;
`ifdef HC05_ECHO_EN
        if (busy_q) begin
          hold_d     = rx_byte;
          hold_vld_d = 1'b1;
        end else begin
          rsp_kind_d = RSP_ECHO;
          rsp_idx_d  = 3'd0;
          load_en    = 1'b1;
          load_byte  = rx_byte;
        end
`endif
      end else if (busy_q) begin
        overrun_d = 1'b1;
      end else begin
        case (pst_q)
          P_IDLE: begin
            if (rx_byte == CH_A)                           pst_d = P_T;
            else if (rx_byte != CH_CR && rx_byte != CH_LF) pst_d = P_DISCARD;
          end
          P_T: begin
            if (rx_byte == CH_T) begin
              pst_d      = P_BODY;
              body_len_d = '0;
            end else begin
              pst_d = P_DISCARD;
            end
          end
          P_BODY: begin
            if (rx_byte == CH_CR)                    pst_d = P_LF;
            else if (body_len_q == LEN_W'(CMD_MAX))  pst_d = P_DISCARD;
            else                                     body_len_d = body_len_q + 1'b1;
          end
          P_LF: begin
            if (rx_byte == CH_LF) begin
              pst_d      = P_IDLE;
              rsp_kind_d = RSP_OK;
              rsp_idx_d  = 3'd0;
              load_en    = 1'b1;
              load_byte  = rsp_rom(1'b0, 3'd0);
            end else begin
              pst_d = P_DISCARD;
            end
          end
          P_DISCARD: begin
            if (rx_byte == CH_LF) begin
              pst_d      = P_IDLE;
              rsp_kind_d = RSP_ERR;
              rsp_idx_d  = 3'd0;
              load_en    = 1'b1;
              load_byte  = rsp_rom(1'b1, 3'd0);
            end
          end
          default: pst_d = P_IDLE;
        endcase
      end
    end

    // Transmit progress: one bit per period, next ROM byte back-to-back
    if (busy_q) begin
      if (tx_tick_q != 10'd0) begin
        tx_tick_d = tx_tick_q - 10'd1;
      end else if (tx_bit_q == 4'd9) begin
        if (rsp_kind_q != RSP_ECHO && rsp_idx_q != rsp_last) begin
          rsp_idx_d = rsp_idx_q + 3'd1;
          load_en   = 1'b1;
          load_byte = rsp_rom(rsp_kind_q == RSP_ERR, rsp_idx_q + 3'd1);
        end else begin
          busy_d    = 1'b0;
          tx_line_d = 1'b1;
          if (rsp_kind_q == RSP_OK)  cmd_count_d = cmd_count_q + 8'd1;
          if (rsp_kind_q == RSP_ERR) err_count_d = err_count_q + 8'd1;
`ifdef HC05_ECHO_EN
          // A byte parked during this transmission goes out next
          if (hold_vld_d) begin
            hold_vld_d = 1'b0;
            rsp_kind_d = RSP_ECHO;
            load_en    = 1'b1;
            load_byte  = hold_d;
          end
`endif
        end
      end else begin
        tx_line_d = tx_sr_q[0];
        tx_sr_d   = {1'b1, tx_sr_q[8:1]};
        tx_bit_d  = tx_bit_q + 4'd1;
        tx_tick_d = tx_cpd_q - 10'd1;
      end
    end

    // Data mode holds the parser idle, abandoning any partial command
    if (!at_mode) pst_d = P_IDLE;

    // Start a new frame: start bit goes out immediately
    if (load_en) begin
      busy_d    = 1'b1;
      tx_line_d = 1'b0;
      tx_sr_d   = {1'b1, load_byte};
      tx_bit_d  = 4'd0;
      tx_cpd_d  = cpd;
      tx_tick_d = cpd - 10'd1;
    end
  end

  assign tx_line    = tx_line_q;
  assign busy       = busy_q;
  assign data_byte  = data_byte_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;
  assign cmd_count  = cmd_count_q;
  assign err_count  = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_hc05_at_responder.sv
// ============================================================================
// Module      : tb_hc05_at_responder
// Description : Scoreboard bench for hc05_at_responder. Stimulus pushes the
//               expected tx bytes / data bytes; independent monitors decode
//               tx_line and data_valid and compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hc05_at_responder;

  localparam int PERIOD = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] cycles_per_databit;
  logic       at_mode;
  logic       rx_line;
  logic       tx_line;
  logic [7:0] data_byte;
  logic       data_valid;
  logic       framing_err;
  logic       overrun;
  logic       busy;
  logic [7:0] cmd_count;
  logic [7:0] err_count;

  always #(PERIOD/2) clock = ~clock;

  hc05_at_responder dut (
    .clock              (clock),
    .reset              (reset),
    .cycles_per_databit (cycles_per_databit),
    .at_mode            (at_mode),
    .rx_line            (rx_line),
    .tx_line            (tx_line),
    .data_byte          (data_byte),
    .data_valid         (data_valid),
    .framing_err        (framing_err),
    .overrun            (overrun),
    .busy               (busy),
    .cmd_count          (cmd_count),
    .err_count          (err_count)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         bit_cyc  = 26;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_data[$];
  bit         ignore_tx = 1'b0;
  bit         check_lat = 1'b0;
  time        last_start = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         fe0, ov0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clock);
    last_start = $time;
    rx_line = 1'b0;
    repeat (bit_cyc) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (bit_cyc) @(negedge clock);
    end
    rx_line = stop_bit;
    repeat (bit_cyc) @(negedge clock);
    rx_line = 1'b1;
  endtask

  task automatic send_cmd(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    send_byte(8'h0D, 1'b1);
    send_byte(8'h0A, 1'b1);
  endtask

  task automatic push_ok();
    exp_tx.push_back(8'h4F); exp_tx.push_back(8'h4B);
    exp_tx.push_back(8'h0D); exp_tx.push_back(8'h0A);
  endtask

  task automatic push_err();
    exp_tx.push_back(8'h45); exp_tx.push_back(8'h52); exp_tx.push_back(8'h52);
    exp_tx.push_back(8'h4F); exp_tx.push_back(8'h52);
    exp_tx.push_back(8'h0D); exp_tx.push_back(8'h0A);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_tx.size() != 0) && n < 20000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20000) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout, busy=%0b pending=%0d expected idle", name, busy, exp_tx.size());
    end
    repeat (2 * bit_cyc) @(negedge clock);
  endtask

  // Pulse observers
  always @(negedge clock) begin
    if (framing_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (overrun === 1'b1)     ov_cnt <= ov_cnt + 1;
  end

  // Data-mode monitor
  always @(negedge clock) begin
    if (!reset && data_valid === 1'b1) begin
      if (exp_data.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL data_unexpected: got 0x%02h expected none", data_byte);
      end else begin
        check("data_byte", {24'd0, data_byte}, {24'd0, exp_data.pop_front()});
      end
    end
  end

  // tx_line decoder and scoreboard
  logic [7:0] mon_b;
  logic       mon_stp;
  time        mon_t;
  int         mon_c;
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && tx_line === 1'b0) begin
        mon_t = $time;
        mon_c = bit_cyc;
        if (check_lat) begin
          check_lat = 1'b0;
          check("rsp_latency", int'((mon_t - last_start) / PERIOD), mon_c / 2 + 9 * mon_c + 2);
        end
        repeat (mon_c / 2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          repeat (mon_c) @(negedge clock);
          mon_b[i] = tx_line;
        end
        repeat (mon_c) @(negedge clock);
        mon_stp = tx_line;
        if (!ignore_tx) begin
          if (exp_tx.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_unexpected: got 0x%02h expected none", mon_b);
          end else begin
            check("tx_byte", {23'd0, mon_stp, mon_b}, {23'd0, 1'b1, exp_tx.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #(1_500_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; at_mode = 1'b1; rx_line = 1'b1;
    cycles_per_databit = 10'd26; bit_cyc = 26;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_tx_line",    tx_line, 1);
    check("rst_busy",       busy, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_framing",    framing_err, 0);
    check("rst_overrun",    overrun, 0);
    check("rst_data_byte",  data_byte, 0);
    check("rst_cmd_count",  cmd_count, 0);
    check("rst_err_count",  err_count, 0);

    // Basic OK with latency and busy duration
    push_ok();
    check_lat = 1'b1;
    send_cmd("AT");
    repeat (1028) @(negedge clock);
    check("busy_during_ok", busy, 1);
    @(negedge clock);
    check("busy_after_ok", busy, 0);
    check("cmd_count_t1", cmd_count, 1);
    wait_idle("t1_idle");

    // Command with body, then garbage
    push_ok();
    send_cmd("AT+NAME=X");
    wait_idle("t2_ok_idle");
    push_err();
    send_cmd("XY");
    wait_idle("t2_err_idle");
    check("err_count_t2", err_count, 1);
    check("cmd_count_t2", cmd_count, 2);

    // Body length boundary: 33 -> ERROR, 32 -> OK
    push_err();
    send_byte(8'h41, 1'b1); send_byte(8'h54, 1'b1);
    for (int i = 0; i < 33; i++) send_byte(8'h42, 1'b1);
    send_byte(8'h0D, 1'b1); send_byte(8'h0A, 1'b1);
    wait_idle("t3_long_idle");
    check("err_count_long", err_count, 2);
    push_ok();
    send_byte(8'h41, 1'b1); send_byte(8'h54, 1'b1);
    for (int i = 0; i < 32; i++) send_byte(8'h42, 1'b1);
    send_byte(8'h0D, 1'b1); send_byte(8'h0A, 1'b1);
    wait_idle("t3_max_idle");
    check("cmd_count_max", cmd_count, 3);
    send_byte(8'h0D, 1'b1); send_byte(8'h0A, 1'b1);
    repeat (12 * bit_cyc) @(negedge clock);
    check("crlf_busy",      busy, 0);
    check("crlf_cmd_count", cmd_count, 3);
    check("crlf_err_count", err_count, 2);

    // Framing error between 'A' and 'T' leaves parser untouched
    fe0 = fe_cnt;
    push_ok();
    send_byte(8'h41, 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (2 * bit_cyc) @(negedge clock);
    send_byte(8'h54, 1'b1); send_byte(8'h0D, 1'b1); send_byte(8'h0A, 1'b1);
    wait_idle("t4_idle");
    check("framing_pulses", fe_cnt - fe0, 1);
    check("cmd_count_t4",   cmd_count, 4);

    // Data mode
    at_mode = 1'b0;
    exp_data.push_back(8'hA5); exp_data.push_back(8'h3C);
`ifdef HC05_ECHO_EN
    exp_tx.push_back(8'hA5); exp_tx.push_back(8'h3C);
`endif
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    wait_idle("t5_idle");
    check("data_all_seen",  exp_data.size(), 0);
    check("data_byte_last", data_byte, 8'h3C);
    check("cmd_count_t5",   cmd_count, 4);
    check("err_count_t5",   err_count, 2);

    // at_mode toggle abandons a partial command
    at_mode = 1'b1;
    send_byte(8'h41, 1'b1); send_byte(8'h54, 1'b1);
    at_mode = 1'b0;
    repeat (20) @(negedge clock);
    at_mode = 1'b1;
    send_byte(8'h0D, 1'b1); send_byte(8'h0A, 1'b1);
    repeat (12 * bit_cyc) @(negedge clock);
    check("toggle_cmd_count", cmd_count, 4);
    check("toggle_err_count", err_count, 2);

    // Overrun during response; dropped 'A' must not reach the parser
    ov0 = ov_cnt;
    push_ok();
    send_cmd("AT");
    send_byte(8'h41, 1'b1);
    wait_idle("t6_ok_idle");
    check("overrun_pulses", ov_cnt - ov0, 1);
    check("cmd_count_t6",   cmd_count, 5);
    push_err();
    send_byte(8'h54, 1'b1); send_byte(8'h0D, 1'b1); send_byte(8'h0A, 1'b1);
    wait_idle("t6_err_idle");
    check("err_count_t6", err_count, 3);

    // Reset in the start bit of the second response byte
    ignore_tx = 1'b1;
    send_cmd("AT");
    n = 0;
    while (busy !== 1'b1 && n < 1000) begin @(negedge clock); n++; end
    check("busy_before_reset", busy, 1);
    repeat (10 * bit_cyc - 6) @(negedge clock);
    check("tx_low_before_reset", tx_line, 0);
    reset = 1'b1;
    @(negedge clock);
    check("rstmid_tx_line",   tx_line, 1);
    check("rstmid_cmd_count", cmd_count, 0);
    check("rstmid_err_count", err_count, 0);
    check("rstmid_busy",      busy, 0);
    reset = 1'b0;
    repeat (12 * bit_cyc) @(negedge clock);
    exp_tx.delete();
    ignore_tx = 1'b0;

    // Bit-period floor: 2 requested, link runs at 4
    cycles_per_databit = 10'd2;
    bit_cyc = 4;
    repeat (10) @(negedge clock);
    push_ok();
    check_lat = 1'b1;
    send_cmd("AT");
    wait_idle("t7_idle");
    check("cmd_count_t7", cmd_count, 1);

    check("tx_queue_empty",   exp_tx.size(), 0);
    check("data_queue_empty", exp_data.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
